// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: hazard events in,
// stage enables/flushes and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_rd;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_mem_rd, ex_branch_taken,
    output dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en,
    input  id_ex_flush, ex_mem_en, mem_wb_flush,
    input  halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_mem_rd, ex_branch_taken,
    input  dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en,
    output id_ex_flush, ex_mem_en, mem_wb_flush,
    output halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use,
// taken-branch and data-memory-wait handling with timeout halt.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t           state, state_n;
  logic [7:0]       wcnt, wcnt_n;
  logic             halted, halted_n;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic freeze, lu, hit1, hit2;
  logic pc_en, if_id_en, if_id_flush;
  logic id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_flush;

  assign freeze = hz.dmem_req & ~hz.dmem_ready;
  assign hit1   = hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd);
  assign hit2   = hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd);
  assign lu     = hz.ex_mem_rd & (hz.ex_rd != 5'd0)
                & (hit1 | hit2);

  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    halted_n     = halted;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else begin
      unique case (state)
        HALT: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end
        RUN, MEM_WAIT: begin
          if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
          // ready on the last wait cycle beats the timeout
          if (state == RUN) begin
            if (freeze) begin
              state_n = MEM_WAIT;
              wcnt_n  = 8'd1;
            end
          end else if (!freeze) begin
            state_n = RUN;
            wcnt_n  = 8'd0;
          end else if (wcnt == 8'(MAX_WAIT - 1)) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            wcnt_n = wcnt + 8'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_n;
      wcnt   <= wcnt_n;
      halted <= halted_n;
      if (state != HALT && !pc_en)
        stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.halted       = halted;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MAX_WAIT=4:
// expected controls/counters queued per driven cycle.
module tb_hazard_ctrl;

  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] FRZ = 8'b0000_0010;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] HLT = 8'b0000_0011;
  localparam logic [7:0] RST = 8'b0000_0000;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  hazard_ctrl_if #(.CNT_W(32)) hz ();

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(string tag, logic r,
                      logic [4:0] rs1, logic [4:0] rs2,
                      logic u1, logic u2, logic [4:0] rd,
                      logic mrd, logic br, logic req,
                      logic rdy, logic [7:0] ctl);
    exp_t e;
    logic [7:0] got;
    rst                = r;
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_uses_rs1     = u1;
    hz.id_uses_rs2     = u2;
    hz.ex_rd           = rd;
    hz.ex_mem_rd       = mrd;
    hz.ex_branch_taken = br;
    hz.dmem_req        = req;
    hz.dmem_ready      = rdy;
    if (r) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (!ctl[7] && !ctl[0]) m_sc = m_sc + 1;
      if (ctl[5]) m_fc = m_fc + 1;
    end
    q.push_back('{ctl, m_sc, m_fc});
    @(negedge clk);
    e = q.pop_front();
    got = {hz.pc_en, hz.if_id_en, hz.if_id_flush,
           hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en,
           hz.mem_wb_flush, hz.halted};
    chk({tag, "/ctl"}, {24'd0, got}, {24'd0, e.ctl});
    @(posedge clk);
    #1;
    chk({tag, "/stall_cnt"}, hz.stall_cnt, e.sc);
    chk({tag, "/flush_cnt"}, hz.flush_cnt, e.fc);
  endtask

  task automatic idle(string tag, logic [7:0] ctl);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,
         1'b0, 1'b0, 1'b0, 1'b0, ctl);
  endtask

  task automatic mw(string tag, logic r, logic req,
                    logic rdy, logic br, logic [7:0] ctl);
    step(tag, r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,
         1'b0, br, req, rdy, ctl);
  endtask

  initial begin
    mw("rst0", 1'b1, 1'b0, 1'b0, 1'b0, RST);
    mw("rst1", 1'b1, 1'b1, 1'b0, 1'b1, RST);
    idle("idle", DEF);

    step("lu_rs1", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5,
         1'b1, 1'b0, 1'b0, 1'b0, LU);
    step("lu_x0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,
         1'b1, 1'b0, 1'b0, 1'b0, DEF);
    step("lu_nouse", 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5,
         1'b1, 1'b0, 1'b0, 1'b0, DEF);
    step("lu_nold", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5,
         1'b0, 1'b0, 1'b0, 1'b0, DEF);
    step("lu_rs2", 1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7,
         1'b1, 1'b0, 1'b0, 1'b0, LU);
    step("br_lu", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5,
         1'b1, 1'b1, 1'b0, 1'b0, BR);

    for (int i = 0; i < 3; i++)
      mw("wait3", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("wait3_rel", 1'b0, 1'b1, 1'b1, 1'b0, DEF);
    idle("post_wait", DEF);

    mw("frz_br", 1'b0, 1'b1, 1'b0, 1'b1, FRZ);
    mw("rel_br", 1'b0, 1'b1, 1'b1, 1'b1, BR);

    for (int i = 0; i < 3; i++)
      mw("last_wait", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("last_rel", 1'b0, 1'b1, 1'b1, 1'b0, DEF);
    idle("no_halt", DEF);
    step("lu_after", 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3,
         1'b1, 1'b0, 1'b0, 1'b0, LU);

    mw("mid_wait", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("mid_wait", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("mid_rst", 1'b1, 1'b1, 1'b0, 1'b1, RST);
    idle("after_rst", DEF);
    mw("restart_wait", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("restart_rel", 1'b0, 1'b1, 1'b1, 1'b0, DEF);

    mw("to_rst", 1'b1, 1'b0, 1'b0, 1'b0, RST);
    for (int i = 0; i < 4; i++)
      mw("timeout", 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    mw("halt", 1'b0, 1'b1, 1'b0, 1'b0, HLT);
    mw("halt_rdy", 1'b0, 1'b1, 1'b1, 1'b0, HLT);
    mw("halt_br", 1'b0, 1'b0, 1'b0, 1'b1, HLT);
    step("halt_lu", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5,
         1'b1, 1'b0, 1'b0, 1'b0, HLT);
    mw("halt_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0001);
    idle("halt_clr", DEF);
    mw("br_again", 1'b0, 1'b0, 1'b0, 1'b1, BR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the enable/flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three event sources:
  - load-use hazards (ID vs EX),
  - taken branches/jumps resolved in EX,
  - data-memory wait handshakes from MEM.
- Tracks memory-wait duration with a timeout. Halts the core on timeout.
- Keeps stall and flush performance counters.

Parameters:
- MAX_WAIT, 16, maximum consecutive memory-wait cycles before timeout halt (valid range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of the instruction in EX
- ex_mem_rd  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_req  in  1  MEM stage is issuing a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF_ID enable
- if_id_flush  out  1  IF_ID clear (bubble)
- id_ex_en  out  1  ID_EX enable
- id_ex_flush  out  1  ID_EX clear (bubble)
- ex_mem_en  out  1  EX_MEM enable
- mem_wb_flush  out  1  MEM_WB bubble insert
- halted  out  1  sticky timeout halt indicator
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted/reset
- flush_cnt  out  CNT_W  number of branch flush events

Behaviour:
- States: RUN, MEM_WAIT, HALT. A wait counter wcnt (8 bits) is also held.
- On rst=1 (sampled at clk edge):
  - state=RUN, wcnt=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While rst is high, all enables and flushes are driven 0.

- Definitions:
  - freeze = dmem_req & ~dmem_ready
  - lu = ex_mem_rd & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))

- Outputs are combinational from state plus inputs. Default values: all enables 1, all flushes 0.
- Priority within RUN/MEM_WAIT is freeze > ex_branch_taken > lu:
  - freeze: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_flush=1; all other flushes 0.
  - ex_branch_taken (no freeze): pc_en=1 (target loaded), if_id_flush=1, id_ex_flush=1.
  - lu (no freeze, no branch): pc_en=0, if_id_en=0, id_ex_flush=1 (one bubble); EX_MEM and MEM_WB advance normally.
- A simultaneous branch and lu resolves as the branch case only; the ID instruction is discarded anyway.
- Flush dominates enable: the target register clears even if its enable is 1.

- Transitions:
  - RUN:
    - freeze → MEM_WAIT, wcnt=1.
    - otherwise stay in RUN.
  - MEM_WAIT:
    - ~freeze → RUN, wcnt=0. The release cycle's outputs follow the branch/lu/default rules.
    - freeze and wcnt==MAX_WAIT-1 → HALT, halted=1.
    - freeze otherwise → wcnt=wcnt+1.
  - HALT:
    - All enables 0, mem_wb_flush=1, other flushes 0.
    - Inputs are ignored. The only exit is rst.

- Timeout timing: a memory that never responds produces exactly MAX_WAIT freeze cycles. halted=1 from the next cycle onward.
- A dmem_ready arriving in the cycle where wcnt==MAX_WAIT-1 wins over the timeout: the block returns to RUN.

- Counters (wrap-around on overflow, no saturation):
  - stall_cnt increments on each non-reset, non-HALT cycle with pc_en=0. This covers both freeze and lu cycles.
  - flush_cnt increments on each non-reset cycle with if_id_flush=1.

- dmem_req is held by the MEM stage stable while frozen. This is guaranteed, because EX_MEM is disabled.

Test Plan:
- Load-use, rs1:
  - Stimulus: ex_mem_rd=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
  - Required: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1 for one cycle; stall_cnt 0→1.
  - Repeat with ex_rd=0: no stall.
  - Repeat with id_uses_rs1=0: no stall.
- Branch plus load-use in the same cycle:
  - Stimulus: ex_branch_taken=1 with lu true.
  - Required: pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt 0→1; stall_cnt unchanged.
- Memory wait of 3 cycles:
  - Stimulus: dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1.
  - Required during the wait: all enables 0 and mem_wb_flush=1 for 3 cycles; state MEM_WAIT.
  - Required at release: 4th cycle has default outputs; state returns to RUN; stall_cnt=3.
- Timeout with MAX_WAIT=4:
  - Stimulus: dmem_req=1, dmem_ready=0 held.
  - Required: 4 freeze cycles, then halted=1 and all enables stay 0.
  - Later dmem_ready=1 has no effect.
  - rst=1 for one edge clears halted, both counters, and returns the block to RUN.
- Ready on the last wait cycle with MAX_WAIT=4:
  - Stimulus: dmem_ready=1 in the cycle where wcnt=3.
  - Required: block returns to RUN; halted stays 0.
- Reset mid-wait:
  - Stimulus: rst=1 during MEM_WAIT with wcnt=2.
  - Required: while rst is high, all enables and flushes are 0.
  - After reset: state=RUN, wcnt=0, counters=0.
